// File: rtl/msx_dbg_pkg.sv
// Shared definitions for the debug UART line formatter: FSM states, ASCII constants, nibble-to-hex.
// Latency: n/a (package only).
// Backpressure: n/a.
package msx_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TAG  = 3'd1,
    EQ   = 3'd2,
    HI   = 3'd3,
    LO   = 3'd4,
    NL   = 3'd5
  } dbg_state_t;

  localparam logic [7:0] ASC_EQ = 8'h3D;
  localparam logic [7:0] ASC_NL = 8'h0A;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    logic [7:0] n8;
    n8 = {4'h0, nibble};
    if (nibble < 4'd10) begin
      return 8'h30 + n8;
    end
    return 8'h37 + n8;  // 'A' - 10
  endfunction

endpackage

// File: rtl/dbg_uart_tx_arbiter_rr_arbiter.sv
// Round-robin arbiter with its own rotate pointer; scan starts just above the last winner.
// Latency: grant is combinational from req; pointer moves on the edge a grant is taken.
// Backpressure: pointer holds while enable is low, so a stalled consumer never skips a requester.
// Ports: clk, reset_n, req[N], enable -> grant (one-hot), grant_idx (3b), grant_vld.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] grant,
  output logic [2:0]   grant_idx,
  output logic         grant_vld
);

  // Index where the next scan begins; 0 after reset so req[0] has first priority.
  logic [2:0] ptr_q;
  int         scan_idx;

  always_comb begin
    grant     = '0;
    grant_idx = 3'd0;
    grant_vld = 1'b0;
    scan_idx  = 0;
    for (int off = 0; off < N; off++) begin
      scan_idx = (int'(ptr_q) + off) % N;
      if (!grant_vld && req[scan_idx]) begin
        grant_vld          = 1'b1;
        grant[scan_idx]    = 1'b1;
        grant_idx          = 3'(scan_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 3'd0;
    end else if (enable && grant_vld) begin
      ptr_q <= (grant_idx == 3'(N - 1)) ? 3'd0 : grant_idx + 3'd1;
    end
  end

endmodule

// File: rtl/dbg_uart_tx_arbiter.sv
// Shares one UART byte stream among N_REQ debug probes, emitting "<tag>=<HH>\n" per grant.
// Latency: req sampled at edge n -> bytes on cycles n+1..n+5, next grant no earlier than edge n+7.
// Backpressure: tx_valid/tx_data held stable until tx_ready; any stall length, no retraction.
// Ports: clk, reset_n, req/req_tag/req_value (per requester), ack, tx_data/tx_valid/tx_ready,
//        busy, grant_idx.
module dbg_uart_tx_arbiter
  import msx_dbg_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_tag,
  input  logic [8*N_REQ-1:0] req_value,
  output logic [N_REQ-1:0]   ack,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic [2:0]         grant_idx
);

  dbg_state_t state_q, state_d;

  logic [7:0]       tag_q;
  logic [7:0]       value_q;
  logic [N_REQ-1:0] ack_q;
  logic [2:0]       grant_idx_q;
  // Set for the single IDLE cycle after a line ends, forcing a gap before the next grant.
  logic             cool_q;

  logic [N_REQ-1:0] arb_grant;
  logic [2:0]       arb_idx;
  logic             arb_vld;
  logic             arb_en;
  logic             grant_fire;
  logic             byte_acc;

  assign arb_en     = (state_q == IDLE) && !cool_q;
  assign grant_fire = arb_en && arb_vld;
  assign byte_acc   = (state_q != IDLE) && tx_ready;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .enable    (arb_en),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_fire) state_d = TAG;
      TAG:     if (tx_ready)   state_d = EQ;
      EQ:      if (tx_ready)   state_d = HI;
      HI:      if (tx_ready)   state_d = LO;
      LO:      if (tx_ready)   state_d = NL;
      NL:      if (tx_ready)   state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Tag/value are captured only at grant so later input changes cannot corrupt the line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q       <= 8'h00;
      value_q     <= 8'h00;
      ack_q       <= '0;
      grant_idx_q <= 3'd0;
      cool_q      <= 1'b0;
    end else begin
      ack_q  <= grant_fire ? arb_grant : '0;
      cool_q <= (state_q == NL) && byte_acc;
      if (grant_fire) begin
        tag_q       <= req_tag[{arb_idx, 3'b000} +: 8];
        value_q     <= req_value[{arb_idx, 3'b000} +: 8];
        grant_idx_q <= arb_idx;
      end
    end
  end

  always_comb begin
    tx_data = 8'h00;
    unique case (state_q)
      TAG:     tx_data = tag_q;
      EQ:      tx_data = ASC_EQ;
      HI:      tx_data = hex_ascii(value_q[7:4]);
      LO:      tx_data = hex_ascii(value_q[3:0]);
      NL:      tx_data = ASC_NL;
      default: tx_data = 8'h00;
    endcase
  end

  assign tx_valid  = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign ack       = ack_q;
  assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_dbg_uart_tx_arbiter.sv
module tb_dbg_uart_tx_arbiter;

  localparam int N_REQ = 4;

  logic               clk;
  logic               reset_n;
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_tag;
  logic [8*N_REQ-1:0] req_value;
  logic [N_REQ-1:0]   ack;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic               busy;
  logic [2:0]         grant_idx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  dbg_uart_tx_arbiter #(.N_REQ(N_REQ)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_tag   (req_tag),
    .req_value (req_value),
    .ack       (ack),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_line(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
    exp_q.push_back(b4);
  endtask

  task automatic set_src(input int i, input logic [7:0] t, input logic [7:0] v);
    req_tag[8*i +: 8]   = t;
    req_value[8*i +: 8] = v;
  endtask

  // Returns at the negedge where ack is first seen high (bounded).
  task automatic wait_ack(input string nm, input logic [3:0] exp_ack, input logic [2:0] exp_idx);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({nm, "_ack"}, 32'(ack), 32'(exp_ack));
      check({nm, "_idx"}, 32'(grant_idx), 32'(exp_idx));
      check({nm, "_busy"}, 32'(busy), 32'd1);
    end
  endtask

  task automatic wait_drain(input string nm);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check({nm, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every accepted byte is compared against the head of the scoreboard queue.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(tx_data), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", 32'(tx_data), 32'(e));
        end
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    req       = '0;
    req_tag   = '0;
    req_value = '0;
    tx_ready  = 1'b1;
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_idx", 32'(grant_idx), 32'd0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Contention: all four held, expect 0,1,2,3,0.
    set_src(0, 8'h50, 8'h01);
    set_src(1, 8'h51, 8'h23);
    set_src(2, 8'h52, 8'h45);
    set_src(3, 8'h53, 8'h67);
    push_line(8'h50, 8'h3D, 8'h30, 8'h31, 8'h0A);
    push_line(8'h51, 8'h3D, 8'h32, 8'h33, 8'h0A);
    push_line(8'h52, 8'h3D, 8'h34, 8'h35, 8'h0A);
    push_line(8'h53, 8'h3D, 8'h36, 8'h37, 8'h0A);
    push_line(8'h50, 8'h3D, 8'h30, 8'h31, 8'h0A);
    @(posedge clk);
    #2 req = 4'b1111;
    wait_ack("rr0", 4'b0001, 3'd0);
    @(negedge clk) check("rr0_pulse", 32'(ack), 32'd0);
    wait_ack("rr1", 4'b0010, 3'd1);
    @(negedge clk) check("rr1_pulse", 32'(ack), 32'd0);
    wait_ack("rr2", 4'b0100, 3'd2);
    @(negedge clk) check("rr2_pulse", 32'(ack), 32'd0);
    wait_ack("rr3", 4'b1000, 3'd3);
    @(negedge clk) check("rr3_pulse", 32'(ack), 32'd0);
    wait_ack("rr4", 4'b0001, 3'd0);
    req = '0;
    wait_drain("rr");
    repeat (3) @(negedge clk);

    // Single requester 2.
    set_src(2, 8'h53, 8'h3C);
    push_line(8'h53, 8'h3D, 8'h33, 8'h43, 8'h0A);
    @(posedge clk);
    #2 req = 4'b0100;
    wait_ack("single", 4'b0100, 3'd2);
    req = '0;
    @(negedge clk) check("single_pulse", 32'(ack), 32'd0);
    wait_drain("single");
    @(negedge clk);
    check("single_busy_after", 32'(busy), 32'd0);
    check("single_valid_after", 32'(tx_valid), 32'd0);

    // Backpressure during HI.
    set_src(1, 8'h42, 8'h7E);
    push_line(8'h42, 8'h3D, 8'h37, 8'h45, 8'h0A);
    @(posedge clk);
    #2 req = 4'b0010;
    wait_ack("bp", 4'b0010, 3'd1);
    req = '0;
    @(posedge clk);
    @(posedge clk);
    #2 tx_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(tx_valid), 32'd1);
      check("bp_data", 32'(tx_data), 32'h37);
    end
    @(posedge clk);
    #2 tx_ready = 1'b1;
    wait_drain("bp");

    // Capture freeze: value changes right after ack.
    set_src(0, 8'h41, 8'h12);
    push_line(8'h41, 8'h3D, 8'h31, 8'h32, 8'h0A);
    @(posedge clk);
    #2 req = 4'b0001;
    wait_ack("cap", 4'b0001, 3'd0);
    req = '0;
    req_value[7:0] = 8'hFF;
    req_tag[7:0]   = 8'h5A;
    wait_drain("cap");

    // Hex edge values on requester 3.
    set_src(3, 8'h44, 8'h00);
    push_line(8'h44, 8'h3D, 8'h30, 8'h30, 8'h0A);
    @(posedge clk);
    #2 req = 4'b1000;
    wait_ack("hex00", 4'b1000, 3'd3);
    req = '0;
    set_src(3, 8'h44, 8'h9A);
    push_line(8'h44, 8'h3D, 8'h39, 8'h41, 8'h0A);
    @(posedge clk);
    #2 req = 4'b1000;
    wait_ack("hex9a", 4'b1000, 3'd3);
    req = '0;
    set_src(3, 8'h44, 8'hFF);
    push_line(8'h44, 8'h3D, 8'h46, 8'h46, 8'h0A);
    @(posedge clk);
    #2 req = 4'b1000;
    wait_ack("hexff", 4'b1000, 3'd3);
    req = '0;
    wait_drain("hex");

    // Reset during LO: only TAG/EQ/HI reach the stream.
    set_src(2, 8'h58, 8'h5C);
    exp_q.push_back(8'h58);
    exp_q.push_back(8'h3D);
    exp_q.push_back(8'h35);
    @(posedge clk);
    #2 req = 4'b0100;
    wait_ack("abort", 4'b0100, 3'd2);
    req = '0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_valid", 32'(tx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_queue", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    set_src(1, 8'h4B, 8'h80);
    set_src(3, 8'h4C, 8'h0F);
    push_line(8'h4B, 8'h3D, 8'h38, 8'h30, 8'h0A);
    push_line(8'h4C, 8'h3D, 8'h30, 8'h46, 8'h0A);
    @(posedge clk);
    #2 req = 4'b1010;
    wait_ack("post_rst1", 4'b0010, 3'd1);
    req[1] = 1'b0;
    wait_ack("post_rst3", 4'b1000, 3'd3);
    req = '0;
    wait_drain("post_rst");
    @(negedge clk);
    check("end_valid", 32'(tx_valid), 32'd0);
    check("end_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
